histogram_builder: RTL

HISTOGRAM_BUILDER -- requirements
Module: histogram_builder

---
 rtl/histogram_builder_pkg.sv | 15 +
 rtl/histogram_builder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/histogram_builder_pkg.sv
// Shared definitions for the histogram builder: controller states and default widths.
package histogram_builder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DRAIN = 2'd3
  } hist_state_e;

  localparam int HIST_DATA_WIDTH = 17;
  localparam int HIST_ADDR_WIDTH = 8;
  localparam logic [HIST_DATA_WIDTH-1:0] HIST_MAX = {HIST_DATA_WIDTH{1'b1}};

endpackage

// File: rtl/histogram_builder.sv
// Histogram builder: clears an external dual-port SRAM, then does a two-stage
// read/increment/write per pixel with same-bin forwarding between consecutive pixels.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start_i, SRAM untouched
//   ST_CLEAR | writing zero to every bin, ascending, one per cycle
//   ST_ACCUM | accepting pixels; stage 0 reads, stage 1 writes bin+1
//   ST_DRAIN | single cycle carrying stage 1 of the last pixel; done_o
module histogram_builder
  import histogram_builder_pkg::*;
#(
  parameter int DATA_WIDTH = HIST_DATA_WIDTH,
  parameter int ADDR_WIDTH = HIST_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  pix_valid_i,
  input  logic [ADDR_WIDTH-1:0] pix_data_i,
  input  logic                  pix_last_i,
  output logic                  pix_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sat_o,
  output logic                  sram_csb0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  output logic                  sram_csb1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr1_o,
  input  logic [DATA_WIDTH-1:0] sram_dout1_i
);

  localparam logic [DATA_WIDTH-1:0] BIN_MAX  = {DATA_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = {ADDR_WIDTH{1'b1}};

  hist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_left_q;
  logic                  s1_valid_q;
  logic                  s1_fwd_q;
  logic [ADDR_WIDTH-1:0] s1_bin_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic                  sat_q;

  logic                  accept;
  logic                  hazard;
  logic                  s1_sat;
  logic [DATA_WIDTH-1:0] s1_old;
  logic [DATA_WIDTH-1:0] s1_new;

  assign accept = (state_q == ST_ACCUM) && pix_valid_i;
  // Same bin as the write in flight: skip the read and reuse the value being written.
  assign hazard = accept && s1_valid_q && (s1_bin_q == pix_data_i);
  assign s1_old = s1_fwd_q ? fwd_data_q : sram_dout1_i;
  assign s1_sat = (s1_old == BIN_MAX);
  assign s1_new = s1_sat ? BIN_MAX : s1_old + DATA_WIDTH'(1);
  assign sat_o  = sat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      clr_left_q <= '0;
      s1_valid_q <= 1'b0;
      s1_fwd_q   <= 1'b0;
      s1_bin_q   <= '0;
      fwd_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      s1_fwd_q   <= hazard;
      if (accept) s1_bin_q <= pix_data_i;
      if (hazard) fwd_data_q <= s1_new;
      if (state_q == ST_IDLE && start_i) clr_left_q <= LAST_BIN;
      else if (state_q == ST_CLEAR)      clr_left_q <= clr_left_q - ADDR_WIDTH'(1);
      if (state_q == ST_IDLE && start_i) sat_q <= 1'b0;
      else if (s1_valid_q && s1_sat)     sat_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pix_ready_o  = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    sram_csb0_o  = 1'b1;
    sram_addr0_o = '0;
    sram_din0_o  = '0;
    sram_csb1_o  = 1'b1;
    sram_addr1_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy_o       = 1'b1;
        sram_csb0_o  = 1'b0;
        // Down-counter walks the address upward through its complement.
        sram_addr0_o = ~clr_left_q;
        if (clr_left_q == '0) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        busy_o      = 1'b1;
        pix_ready_o = 1'b1;
        if (accept && pix_last_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (s1_valid_q) begin
      sram_csb0_o  = 1'b0;
      sram_addr0_o = s1_bin_q;
      sram_din0_o  = s1_new;
    end
    if (accept && !hazard) begin
      sram_csb1_o  = 1'b0;
      sram_addr1_o = pix_data_i;
    end
  end

endmodule
